// File: rtl/mem_lsu.sv
// Load/store unit between a CPU request port and a single-ported word memory.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.

module mem_lsu_lane #(
    parameter int VEC_W = 8
) (
    input  logic             sel,
    input  logic [VEC_W-1:0] old_byte,
    input  logic [VEC_W-1:0] new_byte,
    output logic [VEC_W-1:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module mem_lsu #(
    parameter logic [7:0] IO_WORD = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_clk_enable,
    output logic [7:0]  mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic [7:0]  mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } lsu_req_t;

    logic [1:0]  state;
    lsu_req_t    req_q;
    logic [31:0] wr_word_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        clk_en_q;
    logic        req_err;

    logic [NUM_LANES-1:0]            lane_sel;
    logic [NUM_LANES-1:0][VEC_W-1:0] old_lanes;
    logic [NUM_LANES-1:0][VEC_W-1:0] new_lanes;
    logic [NUM_LANES-1:0][VEC_W-1:0] merged_lanes;
    logic [31:0]                     shifted;
    logic [31:0]                     load_data;

    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (req_size != 2'b10 && req_addr[9:2] == IO_WORD);
    end

    // Sub-word store data is replicated across lanes; lane_sel picks which ones land.
    always_comb begin
        case (req_q.size)
            2'b00:   lane_sel = 4'b0001 << req_q.addr[1:0];
            2'b01:   lane_sel = req_q.addr[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
        case (req_q.size)
            2'b00:   new_lanes = {4{req_q.wdata[7:0]}};
            2'b01:   new_lanes = {2{req_q.wdata[15:0]}};
            default: new_lanes = req_q.wdata;
        endcase
        old_lanes = mem_read_data;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mem_lsu_lane #(.VEC_W(VEC_W)) u_lane (
            .sel      (lane_sel[g]),
            .old_byte (old_lanes[g]),
            .new_byte (new_lanes[g]),
            .merged   (merged_lanes[g])
        );
    end

    always_comb begin
        shifted = mem_read_data >> {req_q.addr[1:0], 3'b000};
        case (req_q.size)
            2'b00:   load_data = {{24{~req_q.uns & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~req_q.uns & shifted[15]}}, shifted[15:0]};
            default: load_data = mem_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            wr_word_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            clk_en_q <= 1'b1;
            case (state)
                IDLE: if (req_valid) begin
                    req_q   <= '{req_write, req_size, req_unsigned, req_addr, req_wdata};
                    rdata_q <= '0;
                    err_q   <= req_err;
                    if (req_err)
                        state <= RESP;
                    else if (req_write && req_size == 2'b10) begin
                        wr_word_q <= req_wdata;
                        state     <= WRITE;
                    end else
                        state <= READ;
                end
                READ: begin
                    if (req_q.write) begin
                        wr_word_q <= merged_lanes;
                        state     <= WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP:  if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready         = (state == IDLE);
    assign resp_valid        = (state == RESP);
    assign resp_rdata        = rdata_q;
    assign resp_err          = err_q;
    assign mem_clk_enable    = clk_en_q;
    assign mem_read_address  = req_q.addr[9:2];
    assign mem_write_address = req_q.addr[9:2];
    assign mem_write_data    = wr_word_q;
    assign mem_write_enable  = (state == WRITE);
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, corner sequences, and random
// requests checked against an arithmetic reference model over a word memory.

module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_clk_enable, mem_write_enable;
    logic [7:0]  mem_read_address, mem_write_address;
    logic [31:0] mem_read_data, mem_write_data;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    logic [7:0]  last_wa;
    logic [31:0] last_wd;
    logic        tb_we = 1'b0;
    logic [7:0]  tb_wa;
    logic [31:0] tb_wd;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_lsu #(.IO_WORD(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_clk_enable(mem_clk_enable),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable)
    );

    assign mem_read_data = mem[mem_read_address];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_write_address] <= mem_write_data;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_write_address;
            last_wd <= mem_write_data;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Reference: plain shift/mask arithmetic over the old word.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [9:0] a, input logic [31:0] wd,
                                  input logic [31:0] old, output logic [31:0] rd,
                                  output logic err, output int lat, output logic [31:0] nw);
        int sh;
        logic [31:0] mask, v;
        sh   = int'(a[1:0]) * 8;
        mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        err  = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0) ||
               (sz != 2 && a[9:2] == 8'hFF);
        rd = 0;
        nw = old;
        if (err) lat = 1;
        else if (!w) begin
            v = (old >> sh) & mask;
            if (!u && sz != 2 && v[(sz == 0) ? 7 : 15]) v = v | ~mask;
            rd  = v;
            lat = 2;
        end else begin
            nw  = (old & ~(mask << sh)) | ((wd << sh) & (mask << sh));
            lat = (sz == 2) ? 2 : 3;
        end
    endfunction

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [9:0] a, input logic [31:0] wd, input int hold,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nwr, output logic [7:0] wa, output logic [31:0] wdat);
        int c0;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        c0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
            req_addr = 10'h000; req_wdata = $urandom;
            @(negedge clk);
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", {31'd0, resp_err}, {31'd0, er});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        nwr  = wr_cnt - c0;
        wa   = last_wa;
        wdat = last_wd;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [9:0]  a;
        logic [31:0] wd;
        int          hold;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
        int          ewr;
        logic [7:0]  ewa;
        logic [31:0] ewd;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [31:0] rd, ewd_m, nw, old;
        logic        er, eer;
        int          lat, elat, nwr, c0;
        logic [7:0]  wa;
        logic [31:0] wdat;
        logic        w, u;
        logic [1:0]  sz;
        logic [9:0]  a;
        logic [31:0] wd;

        tbl[0]  = '{0, 2'd0, 0, 10'h041, 32'h0,    0, 32'hFFFFFFAA, 0, 2, 0, 8'h00, 32'h0};
        tbl[1]  = '{0, 2'd0, 1, 10'h041, 32'h0,    0, 32'h000000AA, 0, 2, 0, 8'h00, 32'h0};
        tbl[2]  = '{0, 2'd1, 0, 10'h042, 32'h0,    0, 32'hFFFF8899, 0, 2, 0, 8'h00, 32'h0};
        tbl[3]  = '{0, 2'd0, 0, 10'h040, 32'h0,    0, 32'hFFFFFFBB, 0, 2, 0, 8'h00, 32'h0};
        tbl[4]  = '{1, 2'd1, 0, 10'h042, 32'h1234, 0, 32'h0,        0, 3, 1, 8'h10, 32'h1234AABB};
        tbl[5]  = '{0, 2'd2, 0, 10'h040, 32'h0,    5, 32'h1234AABB, 0, 2, 0, 8'h00, 32'h0};
        tbl[6]  = '{1, 2'd2, 0, 10'h3FC, 32'h1F,   0, 32'h0,        0, 2, 1, 8'hFF, 32'h0000001F};
        tbl[7]  = '{0, 2'd2, 0, 10'h3FC, 32'h0,    0, 32'h0000001F, 0, 2, 0, 8'h00, 32'h0};
        tbl[8]  = '{0, 2'd0, 0, 10'h3FD, 32'h0,    0, 32'h0,        1, 1, 0, 8'h00, 32'h0};
        tbl[9]  = '{0, 2'd2, 0, 10'h002, 32'h0,    0, 32'h0,        1, 1, 0, 8'h00, 32'h0};
        tbl[10] = '{0, 2'd3, 0, 10'h040, 32'h0,    0, 32'h0,        1, 1, 0, 8'h00, 32'h0};
        tbl[11] = '{0, 2'd1, 0, 10'h041, 32'h0,    0, 32'h0,        1, 1, 0, 8'h00, 32'h0};
        tbl[12] = '{1, 2'd0, 0, 10'h3FF, 32'hAB,   0, 32'h0,        1, 1, 0, 8'h00, 32'h0};
        tbl[13] = '{1, 2'd0, 0, 10'h043, 32'h77,   0, 32'h0,        0, 3, 1, 8'h10, 32'h7734AABB};
        tbl[14] = '{0, 2'd0, 0, 10'h043, 32'h0,    0, 32'h00000077, 0, 2, 0, 8'h00, 32'h0};
        tbl[15] = '{0, 2'd1, 0, 10'h040, 32'h0,    0, 32'hFFFFAABB, 0, 2, 0, 8'h00, 32'h0};
        tbl[16] = '{1, 2'd1, 0, 10'h3FE, 32'h5555, 2, 32'h0,        1, 1, 0, 8'h00, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_mem_clk_en", {31'd0, mem_clk_enable}, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_addrs", {16'd0, mem_read_address, mem_write_address}, 32'd0);
        rst_n = 1'b1;
        #1 chk("clk_en_before_edge", {31'd0, mem_clk_enable}, 32'd0);
        @(negedge clk);
        chk("clk_en_after_edge", {31'd0, mem_clk_enable}, 32'd1);

        for (int i = 0; i < 256; i++) poke(i[7:0], $urandom);
        poke(8'h10, 32'h8899AABB);
        poke(8'hFF, 32'h0);

        for (int i = 0; i < 17; i++) begin
            run_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, tbl[i].hold,
                    rd, er, lat, nwr, wa, wdat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].eerr});
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].elat);
            chk($sformatf("vec%0d_writes", i), nwr, tbl[i].ewr);
            if (tbl[i].ewr == 1) begin
                chk($sformatf("vec%0d_waddr", i), {24'd0, wa}, {24'd0, tbl[i].ewa});
                chk($sformatf("vec%0d_wdata", i), wdat, tbl[i].ewd);
            end
        end

        // Reset pulled during the WRITE cycle of a byte store must drop the write.
        poke(8'h20, 32'hCAFEBABE);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h080; req_wdata = 32'h11;
        c0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_read_addr", {24'd0, mem_read_address}, 32'h20);
        chk("rmw_we_in_read", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk);
        #1;
        chk("rmw_we_in_write", {31'd0, mem_write_enable}, 32'd1);
        chk("rmw_waddr", {24'd0, mem_write_address}, 32'h20);
        chk("rmw_wdata", mem_write_data, 32'hCAFEBA11);
        rst_n = 1'b0;
        #1;
        chk("abort_we", {31'd0, mem_write_enable}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_clk_en", {31'd0, mem_clk_enable}, 32'd0);
        chk("abort_wdata", mem_write_data, 32'd0);
        chk("abort_addrs", {16'd0, mem_read_address, mem_write_address}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_write", wr_cnt - c0, 32'd0);
        chk("abort_word_kept", mem[8'h20], 32'hCAFEBABE);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_clk_en_back", {31'd0, mem_clk_enable}, 32'd1);
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a = {8'hFF, 2'($urandom_range(0, 3))};
            wd  = $urandom;
            old = mem[a[9:2]];
            model(w, sz, u, a, wd, old, ewd_m, eer, elat, nw);
            run_req(w, sz, u, a, wd, $urandom_range(0, 2), rd, er, lat, nwr, wa, wdat);
            chk("rand_rdata", rd, ewd_m);
            chk("rand_err", {31'd0, er}, {31'd0, eer});
            chk("rand_latency", lat, elat);
            chk("rand_writes", nwr, (w && !eer) ? 1 : 0);
            if (w && !eer) begin
                chk("rand_waddr", {24'd0, wa}, {24'd0, a[9:2]});
                chk("rand_wdata", wdat, nw);
            end
            chk("rand_mem_word", mem[a[9:2]], nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
